// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: decodes I/S/B/U/J/zimm/shamt formats behind a
// one-entry valid/ready stage, with a sideband tag and a saturating illegal-format counter.
module imm_ext_pipe #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [24:0]         instr,
    input  logic [2:0]          imm_src,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     imm,
    output logic [TAG_W-1:0]    out_tag,
    output logic                illegal,
    output logic [ERRCNT_W-1:0] err_cnt
);

    logic                r_valid;
    logic [XLEN-1:0]     r_imm;
    logic [TAG_W-1:0]    r_tag;
    logic                r_illegal;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic                w_accept;
    logic                w_illegal;
    logic [XLEN-1:0]     w_imm;

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_illegal = (imm_src == 3'b111);

    // instr holds instruction bits [31:7], so instruction bit k is instr[k-7].
    // Signed operands are widened by the size cast, which sign-extends them.
    always_comb begin
        w_imm = '0;
        case (imm_src)
            3'b000: w_imm = XLEN'($signed(instr[24:13]));
            3'b001: w_imm = XLEN'($signed({instr[24:18], instr[4:0]}));
            3'b010: w_imm = XLEN'($signed({instr[24], instr[0], instr[23:18],
                                           instr[4:1], 1'b0}));
            3'b011: w_imm = XLEN'($signed({instr[24:5], 12'b0}));
            3'b100: w_imm = XLEN'($signed({instr[24], instr[12:5], instr[13],
                                           instr[23:14], 1'b0}));
            3'b101: w_imm = XLEN'(instr[12:8]);
            3'b110: w_imm = (XLEN == 64) ? XLEN'(instr[18:13]) : XLEN'(instr[17:13]);
            default: w_imm = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_imm     <= '0;
            r_tag     <= '0;
            r_illegal <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_valid   <= 1'b1;
                r_imm     <= w_imm;
                r_tag     <= in_tag;
                r_illegal <= w_illegal;
                if (w_illegal && (r_err_cnt != '1))
                    r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign imm       = r_imm;
    assign out_tag   = r_tag;
    assign illegal   = r_illegal;
    assign err_cnt   = r_err_cnt;

endmodule
